// File: rtl/sdram_rd_fetch_if.sv
// SDRAM read port between the fetch front end and the controller.
// master drives the request side; slave returns ack and data.
interface sdram_rd_fetch_if #(
  parameter int AW = 22,
  parameter int DW = 16
);
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic [DW-1:0] rd_data;
  logic          rd_data_vld;

  modport master (
    output rd_req, rd_addr,
    input  rd_ack, rd_data, rd_data_vld
  );

  modport slave (
    input  rd_req, rd_addr,
    output rd_ack, rd_data, rd_data_vld
  );
endinterface

// File: rtl/sdram_rd_fetch.sv
// Key-triggered SDRAM burst read with per-word digit display.
// Debounced press -> request -> capture burst -> show digits.
module sdram_rd_fetch #(
  parameter logic [19:0] DEB_CYCLES = 20'd500000,
  parameter int BURST_LEN = 4,
  parameter int DW = 16,
  parameter int AW = 22,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter int HOLD_CYCLES = 8,
  parameter int TMO_CYCLES = 255
) (
  input  logic                clk,
  input  logic                s_rst_n,
  input  logic                key_in,
  sdram_rd_fetch_if.master    mem,
  output logic [2:0]          digit,
  output logic                digit_vld,
  output logic                busy,
  output logic                err
);

  localparam int TW = $clog2(TMO_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [2:0] LAST = 3'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT_DATA, SHOW
  } state_t;

  function automatic logic [2:0] dmap(input logic [2:0] v);
    return (v == 3'd7) ? 3'd6 : v;
  endfunction

  logic        sync1_q, sync2_q;
  logic        deb_q, deb_prev_q, press_q;
  logic [19:0] deb_cnt_q;

  // Debounced level starts low so a key held across reset
  // must be seen released before a press can fire.
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      press_q    <= 1'b0;
      deb_cnt_q  <= '0;
    end else begin
      sync1_q    <= key_in;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      press_q    <= deb_prev_q & ~deb_q;
      if (sync2_q == deb_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DEB_CYCLES - 20'd1) begin
        deb_q     <= sync2_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + 20'd1;
      end
    end
  end

  state_t        state_q;
  logic          req_q;
  logic [AW-1:0] addr_q;
  logic [2:0]    idx_q;
  logic [2:0]    k_q;
  logic [TW-1:0] tmo_q;
  logic [HW-1:0] cyc_q;
  logic [2:0]    digit_q;
  logic          dvld_q;
  logic          err_q;
  logic [2:0]    dbuf_q [8];

  logic [2:0] wd;
  logic [2:0] widx;
  logic [2:0] first;
  logic       take;
  logic       tmo_hit;
  logic       unused_hi;

  assign wd      = dmap(mem.rd_data[2:0]);
  assign widx    = (state_q == REQ) ? 3'd0 : idx_q;
  assign first   = (BURST_LEN == 1) ? wd : dbuf_q[0];
  assign tmo_hit = (tmo_q == TW'(TMO_CYCLES - 1));
  assign take    = mem.rd_data_vld &
                   (((state_q == REQ) & mem.rd_ack) |
                    (state_q == WAIT_DATA));
  assign unused_hi = ^mem.rd_data[DW-1:3];

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= BASE_ADDR;
      idx_q   <= '0;
      k_q     <= '0;
      tmo_q   <= '0;
      cyc_q   <= '0;
      digit_q <= '0;
      dvld_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < 8; i++) dbuf_q[i] <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (press_q) begin
            err_q   <= 1'b0;
            req_q   <= 1'b1;
            tmo_q   <= '0;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (mem.rd_ack) begin
            req_q   <= 1'b0;
            tmo_q   <= '0;
            idx_q   <= '0;
            state_q <= WAIT_DATA;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            req_q   <= 1'b0;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        WAIT_DATA: begin
          if (mem.rd_data_vld) begin
            tmo_q <= '0;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        SHOW: begin
          if (cyc_q == HW'(HOLD_CYCLES)) begin
            if (k_q == LAST) begin
              state_q <= IDLE;
            end else begin
              k_q     <= k_q + 3'd1;
              cyc_q   <= '0;
              digit_q <= dbuf_q[k_q + 3'd1];
              dvld_q  <= 1'b1;
            end
          end else begin
            if (cyc_q == HW'(HOLD_CYCLES - 1)) dvld_q <= 1'b0;
            cyc_q <= cyc_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Word capture overrides the REQ/WAIT_DATA transitions above.
      if (take) begin
        dbuf_q[widx] <= wd;
        idx_q        <= widx + 3'd1;
        if (widx == LAST) begin
          addr_q  <= addr_q + AW'(BURST_LEN);
          state_q <= SHOW;
          k_q     <= '0;
          cyc_q   <= '0;
          digit_q <= first;
          dvld_q  <= 1'b1;
        end
      end
    end
  end

  assign mem.rd_req  = req_q;
  assign mem.rd_addr = addr_q;
  assign digit       = digit_q;
  assign digit_vld   = dvld_q;
  assign busy        = (state_q != IDLE);
  assign err         = err_q;

endmodule

// File: tb/tb_sdram_rd_fetch.sv
// Directed bench for sdram_rd_fetch: debounce, fetch, wrap,
// timeout, ignored press, stray data and async reset.
module tb_sdram_rd_fetch;

  logic       clk = 1'b0;
  logic       s_rst_n;
  logic       key_in;
  logic [2:0] digit;
  logic       digit_vld;
  logic       busy;
  logic       err;

  int nvec = 0;
  int nmis = 0;

  sdram_rd_fetch_if #(.AW(4), .DW(16)) mem ();

  sdram_rd_fetch #(
    .DEB_CYCLES (20'd4),
    .BURST_LEN  (4),
    .DW         (16),
    .AW         (4),
    .BASE_ADDR  (4'd12),
    .HOLD_CYCLES(8),
    .TMO_CYCLES (255)
  ) dut (
    .clk      (clk),
    .s_rst_n  (s_rst_n),
    .key_in   (key_in),
    .mem      (mem),
    .digit    (digit),
    .digit_vld(digit_vld),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Press the key for 10 cycles; return cycles until rd_req.
  task automatic press_req(output int lat);
    lat = 0;
    key_in = 1'b0;
    fork
      begin
        repeat (10) @(negedge clk);
        key_in = 1'b1;
      end
    join_none
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (mem.rd_req) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic serve(input int dly, input bit coinc,
                       input logic [63:0] ws);
    int s;
    repeat (dly) @(negedge clk);
    mem.rd_ack = 1'b1;
    if (coinc) begin
      mem.rd_data_vld = 1'b1;
      mem.rd_data = ws[15:0];
    end
    @(negedge clk);
    mem.rd_ack = 1'b0;
    mem.rd_data_vld = 1'b0;
    chk("req_drop", mem.rd_req, 0);
    s = coinc ? 1 : 0;
    for (int i = s; i < 4; i++) begin
      mem.rd_data = ws[16*i +: 16];
      mem.rd_data_vld = 1'b1;
      @(negedge clk);
    end
    mem.rd_data_vld = 1'b0;
  endtask

  task automatic show_chk(input logic [11:0] e);
    int n;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      for (int h = 0; h < 8; h++) begin
        if (digit_vld && digit == e[3*k +: 3]) n++;
        @(negedge clk);
      end
      chk($sformatf("dig%0d_hold", k), n, 8);
      chk($sformatf("dig%0d_gap", k), {busy, digit_vld}, 2'b10);
      @(negedge clk);
    end
    chk("show_end_busy", busy, 0);
  endtask

  initial begin
    int lat;
    int n;
    bit seen;
    s_rst_n = 1'b0;
    key_in = 1'b1;
    mem.rd_ack = 1'b0;
    mem.rd_data_vld = 1'b0;
    mem.rd_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", mem.rd_req, 0);
    chk("rst_addr", mem.rd_addr, 12);
    chk("rst_digit", digit, 0);
    chk("rst_dvld", digit_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    s_rst_n = 1'b1;
    repeat (10) @(negedge clk);

    key_in = 1'b0;
    repeat (3) @(negedge clk);
    key_in = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (mem.rd_req || busy) seen = 1;
    end
    chk("glitch_noreq", seen, 0);

    press_req(lat);
    chk("deb_latency", lat, 8);
    chk("fetch1_addr", mem.rd_addr, 12);
    serve(2, 0, {16'h0010, 16'h0007, 16'h0005, 16'h0003});
    show_chk({3'd0, 3'd6, 3'd5, 3'd3});
    chk("fetch1_next", mem.rd_addr, 0);
    chk("fetch1_keep", digit, 0);

    press_req(lat);
    chk("tmo_lat", lat, 8);
    chk("tmo_addr", mem.rd_addr, 0);
    n = 1;
    while (mem.rd_req && n < 400) begin
      @(negedge clk);
      if (mem.rd_req) n++;
    end
    chk("tmo_cycles", n, 255);
    chk("tmo_state", {err, busy, mem.rd_req}, 3'b100);
    chk("tmo_addr_kept", mem.rd_addr, 0);

    press_req(lat);
    chk("ign_lat", lat, 8);
    chk("err_cleared", err, 0);
    chk("ign_addr", mem.rd_addr, 0);
    mem.rd_ack = 1'b1;
    mem.rd_data_vld = 1'b1;
    mem.rd_data = 16'h0002;
    @(negedge clk);
    mem.rd_ack = 1'b0;
    mem.rd_data_vld = 1'b0;
    chk("ign_req_drop", mem.rd_req, 0);
    key_in = 1'b0;
    fork
      begin
        repeat (10) @(negedge clk);
        key_in = 1'b1;
      end
    join_none
    seen = 0;
    repeat (14) begin
      @(negedge clk);
      if (mem.rd_req || !busy) seen = 1;
    end
    chk("ign_no_req", seen, 0);
    mem.rd_data = 16'h0001; mem.rd_data_vld = 1'b1;
    @(negedge clk);
    mem.rd_data = 16'h0004;
    @(negedge clk);
    mem.rd_data = 16'h0006;
    @(negedge clk);
    mem.rd_data_vld = 1'b0;
    show_chk({3'd6, 3'd4, 3'd1, 3'd2});
    chk("ign_next", mem.rd_addr, 4);

    mem.rd_data = 16'h0005;
    mem.rd_data_vld = 1'b1;
    @(negedge clk);
    mem.rd_data_vld = 1'b0;
    @(negedge clk);
    chk("stray_idle", {busy, digit_vld, digit}, {2'b00, 3'd6});

    press_req(lat);
    chk("fetch4_addr", mem.rd_addr, 4);
    serve(0, 1, {16'h000C, 16'h0009, 16'h0000, 16'h00FF});
    show_chk({3'd4, 3'd1, 3'd0, 3'd6});
    chk("fetch4_next", mem.rd_addr, 8);

    press_req(lat);
    chk("fetch5_addr", mem.rd_addr, 8);
    serve(1, 0, {16'h0001, 16'h0002, 16'h0003, 16'h0004});
    repeat (5) @(negedge clk);
    chk("pre_rst_show", {busy, digit_vld, digit}, {2'b11, 3'd4});
    #2 s_rst_n = 1'b0;
    key_in = 1'b0;
    #1;
    chk("mid_rst_out",
        {mem.rd_req, digit_vld, busy, err, digit},
        7'b0000000);
    chk("mid_rst_addr", mem.rd_addr, 12);
    @(negedge clk);
    s_rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (mem.rd_req || busy) seen = 1;
    end
    chk("held_key_nopress", seen, 0);
    key_in = 1'b1;
    repeat (10) @(negedge clk);
    press_req(lat);
    chk("repress_lat", lat, 8);
    chk("repress_addr", mem.rd_addr, 12);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule

// File: doc/sdram_rd_fetch.md
Name: sdram_rd_fetch

Overview:
Key-triggered SDRAM read-back front end for the SDRAM test board. A debounced key press issues a read request to the SDRAM controller and captures a burst of read words into a local buffer. It then presents each word, reduced to a 3-bit digit code, to the 7-segment display stage. The display stage consumes `digit` on its `rd` input and `digit_vld` as its key/advance level.

Parameters:
DEB_CYCLES, 20'd500000, cycles the key must be stable before a press is accepted.
BURST_LEN, 4, words fetched per press; one per display digit (range 1–8).
DW, 16, SDRAM read data width.
AW, 22, SDRAM word address width.
BASE_ADDR, 0, first read address after reset.
HOLD_CYCLES, 8, cycles each digit is held valid.
TMO_CYCLES, 255, maximum wait cycles for ack or for all data words.

Ports:
clk  in  1  system clock
s_rst_n  in  1  asynchronous active-low reset
key_in  in  1  raw push-button, active-low, asynchronous to clk
rd_req  out  1  read request to SDRAM controller
rd_addr  out  AW  burst start address; stable while rd_req=1
rd_ack  in  1  controller accepts the request
rd_data  in  DW  read data word
rd_data_vld  in  1  rd_data valid strobe, one word per cycle
digit  out  3  digit code to display stage (0..6)
digit_vld  out  1  digit valid/advance level to display stage
busy  out  1  high in any state other than IDLE
err  out  1  sticky timeout flag

Behaviour:
Reset is decided: `s_rst_n` is asynchronous, active-low; clock is `clk`. All state clears asynchronously on reset. Reset values:
- rd_req=0, rd_addr=BASE_ADDR, digit=0, digit_vld=0, busy=0, err=0.
- FSM=IDLE; buffer, counters and synchronizer cleared (synchronizer to 1, i.e. released).

Key debounce:
- Two-flop synchronizer on `key_in`, followed by a stability counter.
- The debounced level changes only after DEB_CYCLES consecutive identical synchronized samples.
- A falling edge of the debounced level produces a 1-cycle `press` pulse.
- Press-to-pulse latency is DEB_CYCLES+3 cycles.
- Glitches shorter than DEB_CYCLES never produce a pulse.

FSM states: IDLE, REQ, WAIT_DATA, SHOW.
- IDLE: on `press`, clear err, go to REQ. A press in any other state is ignored; no queueing.
- REQ:
  - rd_req=1 with rd_addr held.
  - When rd_ack=1 is sampled: rd_req drops next cycle, go to WAIT_DATA, reset word index.
  - rd_data_vld in the same cycle as rd_ack is accepted as word 0.
- WAIT_DATA: each rd_data_vld stores `rd_data` into buf[idx] and increments idx.
  - When idx reaches BURST_LEN: rd_addr += BURST_LEN, modulo 2^AW (wraps to 0). Go to SHOW.
  - rd_data_vld outside REQ/WAIT_DATA is discarded.
- Timeout: a counter runs in REQ and WAIT_DATA and resets on every ack/vld.
  - At TMO_CYCLES: err=1, rd_req=0, go to IDLE.
  - rd_addr is not advanced; partial data is discarded.
- SHOW: for k = 0..BURST_LEN-1:
  - digit = map(buf[k]); digit_vld=1 for HOLD_CYCLES, then digit_vld=0 for 1 gap cycle.
  - After the last gap, go to IDLE.
  - digit keeps its last value in IDLE.
- Digit mapping: v = rd_data[2:0]. If v==7, digit=6 (saturate, since the display decodes 0..6 only); otherwise digit=v.
- busy=1 exactly when FSM≠IDLE.
- Reset mid-operation: immediate return to reset values. An in-flight controller burst must be discarded by the controller; this block does not drain it.

Test Plan:
- Reset mid-SHOW, key held low across release:
  - Stimulus: assert s_rst_n=0 during SHOW; release with key_in held low.
  - Required: all outputs return to reset values asynchronously. No press fires until key_in goes high and low again, each level stable DEB_CYCLES.
- Debounce:
  - Stimulus: DEB_CYCLES=4; key_in low for 3 cycles, then low for 10 cycles.
  - Required: no rd_req for the 3-cycle pulse. rd_req rises exactly 4+3+1 cycles after the second falling edge.
- Normal fetch:
  - Stimulus: BURST_LEN=4; ack 2 cycles after rd_req; data 0x0003, 0x0005, 0x0007, 0x0010.
  - Required: rd_addr=0. digit sequence 3, 5, 6, 0, each with digit_vld=1 for 8 cycles plus a 1-cycle gap. rd_addr=4 afterwards; busy low after 36 SHOW cycles.
- Address wrap:
  - Stimulus: AW=4, BASE_ADDR=12, four presses.
  - Required: rd_addr sequence 12, 0, 4, 8.
- Timeout:
  - Stimulus: rd_ack never asserted.
  - Required: after 255 cycles in REQ, rd_req=0, err=1, FSM=IDLE, rd_addr unchanged. The next accepted press clears err.
- Ignored press and edge data:
  - Stimulus: press during WAIT_DATA; rd_data_vld in the same cycle as rd_ack; stray rd_data_vld while in IDLE.
  - Required: no second request is issued. The vld coincident with ack is stored as word 0. The stray IDLE vld leaves the buffer unchanged.
